// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core datapath.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam int IMM_W  = 16;

   // ALU operation select; encoding matches the alu_ctr field from control.
   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_SLT  = 3'b101,
      ALU_SLTU = 3'b110,
      ALU_LUI  = 3'b111
   } alu_op_t;

endpackage : mips_pkg

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU: result and zero flag from operands and op.
module alu_core
   import mips_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  alu_op_t           op,
   output logic [WORD_W-1:0] result,
   output logic              zero
);

   // Operation decode; arithmetic wraps silently, there is no carry/overflow.
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLT:  result = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(WORD_W-1){1'b0}}, (a < b)};
         ALU_LUI:  result = {b[IMM_W-1:0], {(WORD_W-IMM_W){1'b0}}};
         default:  result = '0;
      endcase
   end

   // Zero flag always reflects the final result (BEQ relies on SUB here).
   always_comb begin
      zero = (result == '0);
   end

endmodule : alu_core

// File: rtl/alu_exec_stage.sv
// Execute stage: immediate extension, B-operand select, ALU and an optional
// registered copy of the result/zero for pipelined or debug consumers.
module alu_exec_stage
   import mips_pkg::*;
#(
   parameter int WIDTH = WORD_W   // only 32 is supported
)(
   input  logic             clk,
   input  logic             rst,       // asynchronous, active-low
   input  logic [WIDTH-1:0] bus_a,
   input  logic [WIDTH-1:0] bus_b,
   input  logic [15:0]      imm16,
   input  logic             ext_op,
   input  logic             alu_src,
   input  logic [2:0]       alu_ctr,
   input  logic             en,
   output logic [WIDTH-1:0] imm_ext,
   output logic [WIDTH-1:0] alu_b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] result_q,
   output logic             zero_q
);

   logic [WIDTH-1:0] result_d;
   logic             zero_d;

   // Immediate extension and B-operand mux; unaffected by reset.
   always_comb begin
      if (ext_op) begin
         imm_ext = {{(WIDTH-IMM_W){imm16[IMM_W-1]}}, imm16};
      end else begin
         imm_ext = {{(WIDTH-IMM_W){1'b0}}, imm16};
      end
      alu_b = alu_src ? imm_ext : bus_b;
   end

   alu_core u_alu_core (
      .a      (bus_a),
      .b      (alu_b),
      .op     (alu_op_t'(alu_ctr)),
      .result (result),
      .zero   (zero)
   );

   // Output register next-state: load when enabled, otherwise hold.
   always_comb begin
      result_d = result_q;
      zero_d   = zero_q;
      if (en) begin
         result_d = result;
         zero_d   = zero;
      end
   end

   // Output register; reset clears it regardless of clk and en.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule : alu_exec_stage

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, random
// comparison against an arithmetic reference model, and register/reset
// sequences.
module tb_alu_exec_stage;

   logic        clk;
   logic        rst;
   logic [31:0] bus_a;
   logic [31:0] bus_b;
   logic [15:0] imm16;
   logic        ext_op;
   logic        alu_src;
   logic [2:0]  alu_ctr;
   logic        en;
   logic [31:0] imm_ext;
   logic [31:0] alu_b;
   logic [31:0] result;
   logic        zero;
   logic [31:0] result_q;
   logic        zero_q;

   int tests = 0;
   int fails = 0;

   alu_exec_stage #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus_a    (bus_a),
      .bus_b    (bus_b),
      .imm16    (imm16),
      .ext_op   (ext_op),
      .alu_src  (alu_src),
      .alu_ctr  (alu_ctr),
      .en       (en),
      .imm_ext  (imm_ext),
      .alu_b    (alu_b),
      .result   (result),
      .zero     (zero),
      .result_q (result_q),
      .zero_q   (zero_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm;
      logic        ext;
      logic        src;
      logic [2:0]  op;
      logic [31:0] exp_imm_ext;
      logic [31:0] exp_alu_b;
      logic [31:0] exp_result;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic [31:0] a, logic [31:0] b,
                               logic [15:0] imm, logic ext, logic src, logic [2:0] op,
                               logic [31:0] ei, logic [31:0] eb, logic [31:0] er,
                               logic ez);
      vec_t v;
      v.name = name; v.a = a; v.b = b; v.imm = imm; v.ext = ext; v.src = src;
      v.op = op; v.exp_imm_ext = ei; v.exp_alu_b = eb; v.exp_result = er;
      v.exp_zero = ez;
      return v;
   endfunction

   task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: extension from the numeric value of the immediate.
   function automatic logic [31:0] ref_ext(logic [15:0] imm, logic ext);
      longint v = longint'(imm);
      if (ext && v >= 32768) v = v - 65536;       // negative 16-bit value
      return 32'((v + 64'h1_0000_0000) % 64'h1_0000_0000);
   endfunction

   // Reference model: ALU as plain integer arithmetic modulo 2^32.
   function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] op);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = (ua >= 64'h8000_0000) ? ua - 64'h1_0000_0000 : ua;
      longint sb = (ub >= 64'h8000_0000) ? ub - 64'h1_0000_0000 : ub;
      longint m  = 64'h1_0000_0000;
      longint r;
      case (op)
         3'd0:    r = (ua + ub) % m;
         3'd1:    r = (ua - ub + m) % m;
         3'd2:    r = ua & ub;
         3'd3:    r = ua | ub;
         3'd4:    r = ua ^ ub;
         3'd5:    r = (sa < sb) ? 1 : 0;
         3'd6:    r = (ua < ub) ? 1 : 0;
         default: r = (ub % 65536) * 65536;
      endcase
      return 32'(r);
   endfunction

   task automatic apply(logic [31:0] a, logic [31:0] b, logic [15:0] imm,
                        logic ext, logic src, logic [2:0] op);
      bus_a = a; bus_b = b; imm16 = imm; ext_op = ext; alu_src = src; alu_ctr = op;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0;
      apply(32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 3'd0);

      // Directed vectors.
      vecs.push_back(mk("sext",     32'h0,        32'h0,        16'h8001, 1, 1, 3'd0, 32'hFFFF8001, 32'hFFFF8001, 32'hFFFF8001, 0));
      vecs.push_back(mk("zext",     32'h0,        32'h0,        16'h8001, 0, 1, 3'd0, 32'h00008001, 32'h00008001, 32'h00008001, 0));
      vecs.push_back(mk("mux_reg",  32'h0,        32'h12345678, 16'h8001, 1, 0, 3'd0, 32'hFFFF8001, 32'h12345678, 32'h12345678, 0));
      vecs.push_back(mk("add_ovf",  32'h7FFFFFFF, 32'h1,        16'h0,    0, 0, 3'd0, 32'h0,        32'h1,        32'h80000000, 0));
      vecs.push_back(mk("add_wrap", 32'hFFFFFFFF, 32'h1,        16'h0,    0, 0, 3'd0, 32'h0,        32'h1,        32'h0,        1));
      vecs.push_back(mk("sub_eq",   32'h5,        32'h5,        16'h0,    0, 0, 3'd1, 32'h0,        32'h5,        32'h0,        1));
      vecs.push_back(mk("sub_neg",  32'h3,        32'h5,        16'h0,    0, 0, 3'd1, 32'h0,        32'h5,        32'hFFFFFFFE, 0));
      vecs.push_back(mk("and",      32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    0, 0, 3'd2, 32'h0,        32'h0FF00FF0, 32'h00F000F0, 0));
      vecs.push_back(mk("or",       32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    0, 0, 3'd3, 32'h0,        32'h0FF00FF0, 32'hFFF0FFF0, 0));
      vecs.push_back(mk("xor",      32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    0, 0, 3'd4, 32'h0,        32'h0FF00FF0, 32'hFF00FF00, 0));
      vecs.push_back(mk("lui",      32'h0,        32'h0,        16'h1234, 1, 1, 3'd7, 32'h00001234, 32'h00001234, 32'h12340000, 0));
      vecs.push_back(mk("slt_neg",  32'hFFFFFFFF, 32'h1,        16'h0,    0, 0, 3'd5, 32'h0,        32'h1,        32'h1,        0));
      vecs.push_back(mk("sltu_big", 32'hFFFFFFFF, 32'h1,        16'h0,    0, 0, 3'd6, 32'h0,        32'h1,        32'h0,        1));
      vecs.push_back(mk("slt_eq",   32'h7,        32'h7,        16'h0,    0, 0, 3'd5, 32'h0,        32'h7,        32'h0,        1));
      vecs.push_back(mk("sub_imm",  32'h0,        32'h0,        16'hFFFF, 1, 1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        0));

      // Reset state (reset held low from time zero).
      #7;
      check32("reset_result_q", result_q, 32'h0);
      check32("reset_zero_q", {31'b0, zero_q}, 32'h0);

      // Combinational vectors (evaluated while reset is still asserted too).
      foreach (vecs[i]) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].ext, vecs[i].src, vecs[i].op);
         #1;
         check32({vecs[i].name, ".imm_ext"}, imm_ext, vecs[i].exp_imm_ext);
         check32({vecs[i].name, ".alu_b"},   alu_b,   vecs[i].exp_alu_b);
         check32({vecs[i].name, ".result"},  result,  vecs[i].exp_result);
         check32({vecs[i].name, ".zero"},    {31'b0, zero}, {31'b0, vecs[i].exp_zero});
         $display("[TB] vec %-9s a=%08h b=%08h imm=%04h op=%0d -> result=%08h zero=%0b",
                  vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].op, result, zero);
      end

      // Reset wins over en=1 across a rising edge.
      @(negedge clk);
      en = 1'b1;
      apply(32'hDEADBEEF, 32'h0, 16'h0, 1'b0, 1'b0, 3'd0);
      @(posedge clk); #1;
      check32("rst_wins_result_q", result_q, 32'h0);
      check32("rst_comb_result", result, 32'hDEADBEEF);

      // First capture after deassertion.
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check32("capture_result_q", result_q, 32'hDEADBEEF);
      check32("capture_zero_q", {31'b0, zero_q}, 32'h0);
      $display("[TB] seq capture result_q=%08h zero_q=%0b", result_q, zero_q);

      // Hold with en=0 while inputs change to a zero result.
      @(negedge clk);
      en = 1'b0;
      apply(32'h1, 32'h1, 16'h0, 1'b0, 1'b0, 3'd1);
      @(posedge clk); #1;
      check32("hold_result_q", result_q, 32'hDEADBEEF);
      check32("hold_zero_q", {31'b0, zero_q}, 32'h0);
      $display("[TB] seq hold result_q=%08h zero_q=%0b", result_q, zero_q);

      // Mid-cycle async reset clears a nonzero result_q immediately.
      #2;
      rst = 1'b0;
      #1;
      check32("async_rst_result_q", result_q, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Capture a zero result, then async-reset zero_q mid-cycle.
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      check32("zero_cap_result_q", result_q, 32'h0);
      check32("zero_cap_zero_q", {31'b0, zero_q}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check32("async_rst_zero_q", {31'b0, zero_q}, 32'h0);
      $display("[TB] seq async reset result_q=%08h zero_q=%0b", result_q, zero_q);
      @(negedge clk);
      rst = 1'b1;
      en = 1'b0;

      // Random comparison against the reference model, cycling all ops.
      for (int i = 0; i < 10000; i++) begin
         logic [31:0] ra, rb, eb, er;
         logic [15:0] ri;
         logic        re, rs;
         logic [2:0]  rop;
         ra  = $urandom;
         rb  = (i % 5 == 0) ? ra : $urandom;
         ri  = 16'($urandom);
         re  = 1'($urandom);
         rs  = 1'($urandom);
         rop = 3'(i % 8);
         apply(ra, rb, ri, re, rs, rop);
         #1;
         eb = rs ? ref_ext(ri, re) : rb;
         er = ref_alu(ra, eb, rop);
         check32("rand_imm_ext", imm_ext, ref_ext(ri, re));
         check32("rand_result", result, er);
         check32("rand_zero", {31'b0, zero}, {31'b0, (er == 32'h0)});
         if (i % 1000 == 0)
            $display("[TB] rand %0d a=%08h b=%08h op=%0d -> result=%08h zero=%0b",
                     i, ra, eb, rop, result, zero);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_alu_exec_stage
